mpu_commit_tab: RTL

- Parametrised in-order commit table for the MPU, successor to the single-port commit/hazard table entries.
- Allocates issue numbers to dispatched threads in program order and accepts out-of-order commits from NUM_CH TPU-side channels.
- Retires entries strictly in issue order through a valid/ready port.
- Sits between the dispatch FSM (issue side) and the MPU status/MapMan release logic (retire side).

---
 rtl/pkg_mpu.sv | 17 +
 rtl/mpu_commit_decode.sv | 37 +++
 rtl/mpu_commit_tab.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pkg_mpu.sv
// rtl/pkg_mpu.sv - shared MPU commit-table types and default sizes
package pkg_mpu;

    localparam int NUM_ENTRY_HAZARD = 16;
    localparam int NUM_COMMIT_CH    = 2;
    localparam int WIDTH_THREAD_ID  = 8;
    localparam int WIDTH_COMMIT_NO  = $clog2(NUM_ENTRY_HAZARD);

    typedef logic [WIDTH_COMMIT_NO-1:0] mpu_commit_no_t;

    typedef struct packed {
        logic                       Valid;
        logic                       Commit;
        logic [WIDTH_THREAD_ID-1:0] ID;
    } mpu_tab_commit_t;

endpackage

// File: rtl/mpu_commit_decode.sv
// rtl/mpu_commit_decode.sv - per-channel commit numbers to one-hot set vector plus error flag
module mpu_commit_decode #(
    parameter int NUM_ENTRY = 16,
    parameter int NUM_CH    = 2,
    parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
    input  logic [NUM_CH-1:0]          commit_req_i,
    input  logic [NUM_CH*WIDTH_NO-1:0] commit_no_i,
    input  logic [NUM_ENTRY-1:0]       valid_i,
    input  logic [NUM_ENTRY-1:0]       commit_i,
    output logic [NUM_ENTRY-1:0]       set_o,
    output logic                       err_o
);

    logic [NUM_ENTRY-1:0] set_d;
    logic [WIDTH_NO-1:0]  idx;

    // A later channel hitting an entry already claimed this cycle counts as a duplicate.
    always_comb begin
        set_d = '0;
        err_o = 1'b0;
        idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (commit_req_i[c]) begin
                idx = commit_no_i[c*WIDTH_NO +: WIDTH_NO];
                if (!valid_i[idx] || commit_i[idx] || set_d[idx]) begin
                    err_o = 1'b1;
                end else begin
                    set_d[idx] = 1'b1;
                end
            end
        end
    end

    assign set_o = set_d;

endmodule

// File: rtl/mpu_commit_tab.sv
// rtl/mpu_commit_tab.sv - in-order issue/retire table with out-of-order multi-channel commit
module mpu_commit_tab
    import pkg_mpu::*;
#(
    parameter int NUM_ENTRY = NUM_ENTRY_HAZARD,
    parameter int NUM_CH    = NUM_COMMIT_CH,
    parameter int WIDTH_ID  = WIDTH_THREAD_ID,
    parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            I_Flush,
    input  logic                            I_Issue_Req,
    input  logic [WIDTH_ID-1:0]             I_Issue_ID,
    output logic                            O_Issue_Ack,
    output logic [WIDTH_NO-1:0]             O_Issue_No,
    input  logic [NUM_CH-1:0]               I_Commit_Req,
    input  logic [NUM_CH*WIDTH_NO-1:0]      I_Commit_No,
    output logic                            O_Retire_Valid,
    output logic [WIDTH_NO-1:0]             O_Retire_No,
    output logic [WIDTH_ID-1:0]             O_Retire_ID,
    input  logic                            I_Retire_Ready,
    output logic                            O_Full,
    output logic                            O_Empty,
    output logic [$clog2(NUM_ENTRY+1)-1:0]  O_Count,
    output logic                            O_Err_Commit
);

    localparam int CW = $clog2(NUM_ENTRY+1);

    logic [NUM_ENTRY-1:0] valid_q, valid_d;
    logic [NUM_ENTRY-1:0] commit_q, commit_d;
    logic [WIDTH_ID-1:0]  id_q [NUM_ENTRY];
    logic [WIDTH_ID-1:0]  id_d [NUM_ENTRY];
    logic [WIDTH_NO-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_q, err_d;

    logic [NUM_ENTRY-1:0] set_vec;
    logic                 dec_err;
    logic                 issue_fire, retire_fire;

    mpu_commit_decode #(
        .NUM_ENTRY (NUM_ENTRY),
        .NUM_CH    (NUM_CH),
        .WIDTH_NO  (WIDTH_NO)
    ) u_decode (
        .commit_req_i (I_Commit_Req),
        .commit_no_i  (I_Commit_No),
        .valid_i      (valid_q),
        .commit_i     (commit_q),
        .set_o        (set_vec),
        .err_o        (dec_err)
    );

    // Full comes from the registered count only, so a same-cycle retire never frees a slot for issue.
    assign O_Full         = (count_q == CW'(NUM_ENTRY));
    assign O_Empty        = (count_q == '0);
    assign O_Count        = count_q;
    assign O_Err_Commit   = err_q;
    assign O_Issue_Ack    = I_Issue_Req & ~O_Full;
    assign O_Issue_No     = tail_q;
    assign O_Retire_Valid = valid_q[head_q] & commit_q[head_q];
    assign O_Retire_No    = head_q;
    assign O_Retire_ID    = id_q[head_q];

    assign issue_fire  = O_Issue_Ack;
    assign retire_fire = O_Retire_Valid & I_Retire_Ready;

    always_comb begin
        valid_d  = valid_q;
        commit_d = commit_q;
        id_d     = id_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q;
        if (I_Flush) begin
            valid_d  = '0;
            commit_d = '0;
            id_d     = '{default: '0};
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            commit_d = commit_q | set_vec;
            if (retire_fire) begin
                valid_d[head_q]  = 1'b0;
                commit_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            if (issue_fire) begin
                valid_d[tail_q]  = 1'b1;
                commit_d[tail_q] = 1'b0;
                id_d[tail_q]     = I_Issue_ID;
                tail_d           = tail_q + 1'b1;
            end
            count_d = count_q + CW'(issue_fire) - CW'(retire_fire);
            err_d   = err_q | dec_err;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            commit_q <= '0;
            id_q     <= '{default: '0};
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            commit_q <= commit_d;
            id_q     <= id_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule
